// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle core control FSM.
// ILLEGAL_OP_TRAP_EN adds the HALT state and the illegal flag in the control word.
package mc_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;
  localparam int CTRL_OP_W    = 7;

  localparam logic [CTRL_OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [CTRL_OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [CTRL_OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [CTRL_OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [CTRL_OP_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [CTRL_OP_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
    , S_HALT   = 4'd11
`endif
  } state_e;

  // Raw per-state control word; ready_gated marks enables that wait for MemReady.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ready_gated;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle control FSM (master) and the datapath (slave).
// ILLEGAL_OP_TRAP_EN adds the Illegal flag.
interface multicycle_ctrl_fsm_if #(
  parameter int OPCODE_W = 7
);
  logic [OPCODE_W-1:0] op;
  logic                Zero;
  logic                MemReady;
  logic [1:0]          ALUOp;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ResultSrc;
  logic                AdrSrc;
  logic                IRWrite;
  logic                PCWrite;
  logic                RegWrite;
  logic                MemWrite;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                Illegal;
`endif

  modport master (
    input  op, Zero, MemReady,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite
`ifdef ILLEGAL_OP_TRAP_EN
    , output Illegal
`endif
  );

  modport slave (
    output op, Zero, MemReady,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite
`ifdef ILLEGAL_OP_TRAP_EN
    , input Illegal
`endif
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> raw control-word decode for the multi-cycle control FSM.
// ILLEGAL_OP_TRAP_EN adds the HALT decode.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src     = ADR_PC;
        ctrl.src_a       = SRCA_PC;
        ctrl.src_b       = SRCB_FOUR;
        ctrl.alu_op      = ALUOP_ADD;
        ctrl.result_src  = RES_ALURESULT;
        ctrl.ir_write    = 1'b1;
        ctrl.pc_update   = 1'b1;
        ctrl.ready_gated = 1'b1;
      end
      S_DECODE: begin
        ctrl.src_a  = SRCA_OLDPC;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.src_a  = SRCA_RD1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.src_a  = SRCA_RD1;
        ctrl.src_b  = SRCB_RD2;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.src_a  = SRCA_RD1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.src_a      = SRCA_OLDPC;
        ctrl.src_b      = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_BEQ: begin
        ctrl.src_a      = SRCA_RD1;
        ctrl.src_b      = SRCB_RD2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: begin
        ctrl.illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle core: state register, next-state logic, MemReady/Zero gating.
// ILLEGAL_OP_TRAP_EN: unknown opcodes trap into HALT (Illegal=1) instead of retiring as a NOP.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int OPCODE_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.master bus
);

  logic [STATE_W-1:0]  state_q;
  state_e              state;
  state_e              state_nxt;
  state_e              dec_state;
  ctrl_t               ctrl;
  logic [OPCODE_W-1:0] op;
  logic                ready_ok;

  assign op    = bus.op;
  assign state = state_e'(state_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_nxt = S_HALT;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_nxt = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_nxt = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BEQ:      state_nxt = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT:     state_nxt = S_HALT;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  // During reset the selects already present the FETCH word and every enable is held low.
  assign dec_state = rst ? S_FETCH : state;

  mc_ctrl_outdec u_outdec (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  assign ready_ok = !ctrl.ready_gated || bus.MemReady;

  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.ALUSrcA   = ctrl.src_a;
  assign bus.ALUSrcB   = ctrl.src_b;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.IRWrite   = !rst && ctrl.ir_write && ready_ok;
  assign bus.PCWrite   = !rst && ((ctrl.pc_update && ready_ok) || (ctrl.branch && bus.Zero));
  assign bus.RegWrite  = !rst && ctrl.reg_write;
  assign bus.MemWrite  = !rst && ctrl.mem_write;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.Illegal   = ctrl.illegal;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each driven cycle queues the expected control word,
// the negedge monitor compares it. Honors ILLEGAL_OP_TRAP_EN.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.OPCODE_W(7)) bus ();

  multicycle_ctrl_fsm #(.STATE_W(4), .OPCODE_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal}
  localparam logic [13:0] W_RST  = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_F0   = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_F1   = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_DEC  = {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_MADR = {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_MRD  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_MWB  = {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] W_MW   = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] W_EXR  = {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_EXI  = {2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_AWB  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] W_JAL  = {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_BEQ0 = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_BEQ1 = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] W_HALT = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_chk  = 0;
  int  n_pass = 0;

  logic        ill;
  logic [13:0] obs;

`ifdef ILLEGAL_OP_TRAP_EN
  assign ill = bus.Illegal;
`else
  assign ill = 1'b0;
`endif

  assign obs = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, ill};

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue the control word they must produce.
  task automatic cyc(input logic r, input logic [6:0] o, input logic mr, input logic z,
                     input string tag, input logic [13:0] e);
    sb_t t;
    rst          = r;
    bus.op       = o;
    bus.MemReady = mr;
    bus.Zero     = z;
    t.tag = tag;
    t.exp = e;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_eq(mon_e.tag, obs, mon_e.exp);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.op       = '0;
    bus.MemReady = 1'b0;
    bus.Zero     = 1'b0;
    @(posedge clk);
    #1;

    cyc(1, 7'd0, 1, 0, "rst_a", W_RST);
    cyc(1, 7'd0, 1, 1, "rst_b", W_RST);

    // sw interrupted by reset while MEMWRITE waits on memory
    cyc(0, SW, 1,    rb(), "sw_fetch", W_F1);
    cyc(0, SW, rb(), rb(), "sw_dec",   W_DEC);
    cyc(0, SW, rb(), rb(), "sw_madr",  W_MADR);
    cyc(0, SW, 0,    rb(), "sw_mw_a",  W_MW);
    cyc(0, SW, 0,    rb(), "sw_mw_b",  W_MW);
    cyc(1, SW, 0,    1,    "rst_in_mw", W_RST);
    cyc(0, LW, 0,    rb(), "post_rst_fetch", W_F0);

    // lw with one read stall
    cyc(0, LW, 1,    rb(), "lw_fetch",  W_F1);
    cyc(0, LW, rb(), rb(), "lw_dec",    W_DEC);
    cyc(0, LW, rb(), rb(), "lw_madr",   W_MADR);
    cyc(0, LW, 0,    rb(), "lw_mrd_st", W_MRD);
    cyc(0, LW, 1,    rb(), "lw_mrd",    W_MRD);
    cyc(0, LW, rb(), rb(), "lw_wb",     W_MWB);

    // fetch stalled three cycles, then R-type
    for (int i = 0; i < 3; i++) cyc(0, RT, 0, rb(), $sformatf("fetch_stall%0d", i), W_F0);
    cyc(0, RT, 1,    rb(), "fetch_go", W_F1);
    cyc(0, RT, rb(), rb(), "r_dec",    W_DEC);
    cyc(0, RT, rb(), rb(), "r_exec",   W_EXR);
    cyc(0, RT, rb(), rb(), "r_wb",     W_AWB);

    // beq taken, then not taken
    cyc(0, BQ, 1,    rb(), "beq1_fetch", W_F1);
    cyc(0, BQ, rb(), rb(), "beq1_dec",   W_DEC);
    cyc(0, BQ, rb(), 1,    "beq_z1",     W_BEQ1);
    cyc(0, BQ, 1,    rb(), "beq2_fetch", W_F1);
    cyc(0, BQ, rb(), rb(), "beq2_dec",   W_DEC);
    cyc(0, BQ, rb(), 0,    "beq_z0",     W_BEQ0);

    // jal, I-type, unstalled sw
    cyc(0, JL, 1,    rb(), "jal_fetch", W_F1);
    cyc(0, JL, rb(), rb(), "jal_dec",   W_DEC);
    cyc(0, JL, rb(), rb(), "jal",       W_JAL);
    cyc(0, JL, rb(), rb(), "jal_wb",    W_AWB);
    cyc(0, IT, 1,    rb(), "i_fetch",   W_F1);
    cyc(0, IT, rb(), rb(), "i_dec",     W_DEC);
    cyc(0, IT, rb(), rb(), "i_exec",    W_EXI);
    cyc(0, IT, rb(), rb(), "i_wb",      W_AWB);
    cyc(0, SW, 1,    rb(), "sw2_fetch", W_F1);
    cyc(0, SW, rb(), rb(), "sw2_dec",   W_DEC);
    cyc(0, SW, rb(), rb(), "sw2_madr",  W_MADR);
    cyc(0, SW, 1,    rb(), "sw2_mw",    W_MW);

    // undecodable opcode
    cyc(0, BAD, 1,    rb(), "bad_fetch", W_F1);
    cyc(0, BAD, rb(), rb(), "bad_dec",   W_DEC);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++) cyc(0, BAD, 1, 1, $sformatf("halt%0d", i), W_HALT);
    cyc(1, BAD, 1, 1,    "halt_rst",   W_RST);
    cyc(0, LW,  0, rb(), "halt_exit",  W_F0);
`else
    cyc(0, BAD, 1,    rb(), "bad_nop_fetch", W_F1);
    cyc(0, LW,  rb(), rb(), "bad_nop_dec",   W_DEC);
`endif

    @(negedge clk);
    #1;
    check_eq("sb_drain", 14'(sb.size()), 14'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
